// File: rtl/load_data_unit_if.sv
// load_data_unit_pkg / load_data_unit_if
//   Access-size type shared by the load engine and its environment, and the
//   interface that bundles the load engine's pipeline and data-bus signals.
//
//   Pipeline side : req_valid, req_addr, req_msize, req_signed, flush (in)
//                   busy, resp_valid, resp_data, resp_misalign      (out)
//   Data-bus side : dreq_valid, dreq_addr, dreq_size, dreq_strobe   (out)
//                   dresp_data_ok, dresp_data                       (in)
//
//   Modport slave is the load engine's view; modport master is the view of
//   whatever drives it (pipeline plus bus model).

package load_data_unit_pkg;
   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;
endpackage

interface load_data_unit_if;
   import load_data_unit_pkg::*;

   logic        req_valid;
   logic [63:0] req_addr;
   msize_t      req_msize;
   logic        req_signed;
   logic        flush;
   logic        busy;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        resp_misalign;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   msize_t      dreq_size;
   logic [7:0]  dreq_strobe;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;

   modport slave (
      input  req_valid, req_addr, req_msize, req_signed, flush,
      input  dresp_data_ok, dresp_data,
      output busy, resp_valid, resp_data, resp_misalign,
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe
   );

   modport master (
      output req_valid, req_addr, req_msize, req_signed, flush,
      output dresp_data_ok, dresp_data,
      input  busy, resp_valid, resp_data, resp_misalign,
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe
   );
endinterface

// File: rtl/load_data_unit.sv
// load_data_unit
//   Memory-stage load engine. Accepts one load request, issues a single dbus
//   read, waits for the response word, then selects the addressed byte lanes
//   and sign/zero-extends them to 64 bits. Misaligned requests complete
//   without touching the bus. A flush while the bus read is outstanding
//   drains the response instead of reporting it.
//
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : load_data_unit_if.slave (pipeline request/response + dbus)

module load_data_unit
   import load_data_unit_pkg::*;
(
   input logic              clk,
   input logic              reset,
   load_data_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        dreq_valid_q, dreq_valid_d;
   logic [63:0] dreq_addr_q, dreq_addr_d;
   msize_t      dreq_size_q, dreq_size_d;
   logic        signed_q, signed_d;
   logic        resp_valid_q, resp_valid_d;
   logic [63:0] resp_data_q, resp_data_d;
   logic        resp_misalign_q, resp_misalign_d;

   logic        req_aligned;
   logic [63:0] load_value;

   function automatic logic is_aligned(input logic [2:0] off, input msize_t size);
      logic ok;
      case (size)
         MSIZE1:  ok = 1'b1;
         MSIZE2:  ok = (off[0] == 1'b0);
         MSIZE4:  ok = (off[1:0] == 2'b00);
         default: ok = (off == 3'b000);
      endcase
      return ok;
   endfunction

   // Alignment guarantees that shifting right by 8*offset lands every access
   // size on bit 0 (for a word, 8*offset is 0 or 32), so one shifter serves
   // all sizes.
   function automatic logic [63:0] extract(input logic [63:0] data,
                                           input logic [2:0]  off,
                                           input msize_t      size,
                                           input logic        sgn);
      logic [63:0] sh;
      logic [63:0] res;
      sh = data >> {off, 3'b000};
      case (size)
         MSIZE1:  res = {{56{sgn & sh[7]}},  sh[7:0]};
         MSIZE2:  res = {{48{sgn & sh[15]}}, sh[15:0]};
         MSIZE4:  res = {{32{sgn & sh[31]}}, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   assign req_aligned = is_aligned(bus.req_addr[2:0], bus.req_msize);
   assign load_value  = extract(bus.dresp_data, dreq_addr_q[2:0], dreq_size_q, signed_q);

   always_comb begin
      state_d         = state_q;
      dreq_valid_d    = dreq_valid_q;
      dreq_addr_d     = dreq_addr_q;
      dreq_size_d     = dreq_size_q;
      signed_d        = signed_q;
      resp_valid_d    = 1'b0;
      resp_data_d     = resp_data_q;
      resp_misalign_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && !bus.flush) begin
               if (req_aligned) begin
                  state_d      = WAIT;
                  dreq_valid_d = 1'b1;
                  dreq_addr_d  = bus.req_addr;
                  dreq_size_d  = bus.req_msize;
                  signed_d     = bus.req_signed;
               end else begin
                  state_d         = DONE;
                  resp_valid_d    = 1'b1;
                  resp_misalign_d = 1'b1;
                  resp_data_d     = '0;
               end
            end
         end

         WAIT: begin
            if (bus.dresp_data_ok) begin
               dreq_valid_d = 1'b0;
               if (bus.flush) begin
                  state_d = IDLE;
               end else begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  resp_data_d  = load_value;
               end
            end else if (bus.flush) begin
               state_d = DRAIN;
            end
         end

         // The bus read cannot be withdrawn, so keep requesting until its
         // data arrives and then discard it.
         DRAIN: begin
            if (bus.dresp_data_ok) begin
               state_d      = IDLE;
               dreq_valid_d = 1'b0;
            end
         end

         // A request still held high here belongs to the load just finished,
         // so it is never re-accepted.
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         dreq_valid_q    <= 1'b0;
         dreq_addr_q     <= '0;
         dreq_size_q     <= MSIZE1;
         signed_q        <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         resp_misalign_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         dreq_valid_q    <= dreq_valid_d;
         dreq_addr_q     <= dreq_addr_d;
         dreq_size_q     <= dreq_size_d;
         signed_q        <= signed_d;
         resp_valid_q    <= resp_valid_d;
         resp_data_q     <= resp_data_d;
         resp_misalign_q <= resp_misalign_d;
      end
   end

   assign bus.busy          = (state_q != IDLE) || (bus.req_valid && !bus.flush);
   // A flush arriving during DONE must still kill the result, so the
   // registered pulse is gated by the live flush.
   assign bus.resp_valid    = resp_valid_q && !bus.flush;
   assign bus.resp_data     = resp_data_q;
   assign bus.resp_misalign = resp_misalign_q;
   assign bus.dreq_valid    = dreq_valid_q;
   assign bus.dreq_addr     = dreq_addr_q;
   assign bus.dreq_size     = dreq_size_q;
   assign bus.dreq_strobe   = '0;

endmodule

// File: doc/load_data_unit.md
Name: load_data_unit

Overview:
- Memory-stage load engine: turns one pipeline load request into a single dbus read transaction.
- Waits for the bus response, then selects the addressed byte lanes from the 64-bit response word and sign- or zero-extends them to 64 bits.
- It is the read-direction counterpart to the store-side lane/strobe aligner and sits between the memory stage and the data bus.
- Stalls the pipeline while a transaction is outstanding and safely drains bus responses after a pipeline flush.

Parameters:
- none; address and data widths are fixed at 64 bits.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  load request from memory stage; held high until resp_valid is seen
- req_addr  input  64  byte address of the load
- req_msize  input  msize_t  access size: MSIZE1/2/4/8
- req_signed  input  1  1 = sign-extend result, 0 = zero-extend
- flush  input  1  pipeline flush; kills the current request
- busy  output  1  stall request to the pipeline
- resp_valid  output  1  one-cycle result pulse
- resp_data  output  64  extended load result
- resp_misalign  output  1  qualifies resp_valid; address not naturally aligned
- dreq_valid  output  1  dbus read request valid
- dreq_addr  output  64  dbus address (full byte address)
- dreq_size  output  msize_t  dbus access size
- dreq_strobe  output  8  always 8'h00 (read)
- dresp_data_ok  input  1  dbus read data valid this cycle
- dresp_data  input  64  dbus read data, natural byte lanes (byte k at bits 8k+7:8k)

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. All outputs are 0: busy, resp_valid, resp_data, resp_misalign, dreq_valid, dreq_addr, dreq_size. Any in-flight transaction is abandoned and produces no response.
- States: IDLE, WAIT, DRAIN, DONE. All outputs are registered except busy.
- busy = (state != IDLE) || (state == IDLE && req_valid && !flush).
- Alignment check:
  - MSIZE2 needs addr[0] = 0.
  - MSIZE4 needs addr[1:0] = 0.
  - MSIZE8 needs addr[2:0] = 0.
  - MSIZE1 is always aligned.
- IDLE:
  - req_valid && flush: request is ignored; stay in IDLE.
  - req_valid && aligned: latch addr, msize and signed; go to WAIT. dreq_valid = 1 from the next cycle, with dreq_addr = req_addr and dreq_size = req_msize.
  - req_valid && misaligned: go to DONE with resp_misalign = 1 and resp_data = 0. No bus access is made.
- WAIT:
  - dreq_valid, dreq_addr and dreq_size are held stable.
  - dresp_data_ok && !flush: go to DONE and latch the extracted data; dreq_valid drops to 0 in DONE.
  - dresp_data_ok && flush: discard the data; go to IDLE with no response.
  - flush && !dresp_data_ok: go to DRAIN.
- DRAIN:
  - dreq_valid stays 1 because a bus transaction cannot be aborted.
  - On dresp_data_ok: go to IDLE with no response. Further flushes have no effect.
- DONE:
  - resp_valid = 1 for exactly one cycle, then go to IDLE.
  - flush asserted in DONE suppresses resp_valid; go to IDLE.
  - The pipeline must drop or replace req_valid in the cycle after resp_valid. A req_valid still high in DONE is not re-accepted.
- Lane extraction (o = latched addr[2:0]):
  - MSIZE1: byte o.
  - MSIZE2: bytes {o+1, o}, with o[0] = 0.
  - MSIZE4: bits 32*o[2]+31 : 32*o[2].
  - MSIZE8: the full word.
  - Extension: if signed, replicate the MSB of the selected field into bits 63 and up to the field width; otherwise fill with zeros.
- Latency for an aligned load: resp_valid = N+2 cycles after the accepting cycle, where N = cycles from dreq_valid rising to dresp_data_ok (N >= 0).
- Misaligned latency: resp_valid 1 cycle after acceptance.
- dresp_data_ok seen in IDLE or DONE is ignored.

Test Plan:
- Signed byte, addr 0x8000_0003, dresp_data 0x0123_4567_89AB_CDEF after 2 wait cycles -> resp_data 0xFFFF_FFFF_FFFF_FF89, resp_misalign 0, exactly one resp_valid pulse; dreq_addr 0x8000_0003, dreq_size MSIZE1, dreq_strobe 0.
- Lane and extension sweep, same data word:
  - unsigned half @ offset 6 -> 0x0000_0000_0000_0123
  - signed word @ offset 0 -> 0xFFFF_FFFF_89AB_CDEF
  - signed word @ offset 4 -> 0x0000_0000_0123_4567
  - MSIZE8 @ offset 0 -> 0x0123_4567_89AB_CDEF
- Misaligned: MSIZE2 at 0x1001 and MSIZE8 at 0x1004 -> resp_valid with resp_misalign 1 and resp_data 0 one cycle after the request; dreq_valid never asserted.
- Flush in WAIT with dresp_data_ok arriving 3 cycles later -> no resp_valid; dreq_valid stays high until the data_ok cycle, then busy and dreq_valid are 0; a new load then completes normally.
- Simultaneous events:
  - flush and dresp_data_ok in the same WAIT cycle -> no response, IDLE next cycle.
  - data_ok in the same cycle dreq_valid rises (N = 0) -> resp_valid 2 cycles after acceptance.
- Reset asserted asynchronously mid-WAIT -> all outputs 0 immediately. A dresp_data_ok arriving after release creates no response.
